// File: rtl/alu_pkg.sv
// alu_pkg -- shared definitions for the EXE-stage ALU.
//   * opcode_t     : ALU operation codes driven by the decoder
//   * *_BIT        : RFLAGS bit positions written by the ALU
//   * FLAG_MASK    : set of RFLAGS bits the ALU computes (all others pass through)
//   * arith_t      : add/subtract result bundle (value plus CF/AF/OF)
//   * flag_sel_t   : source of the outgoing RFLAGS word
package alu_pkg;

    typedef enum logic [7:0] {
        OP_NOP  = 8'h00,
        OP_ADD  = 8'h01,
        OP_ADC  = 8'h02,
        OP_SUB  = 8'h03,
        OP_SBB  = 8'h04,
        OP_CMP  = 8'h05,
        OP_AND  = 8'h06,
        OP_OR   = 8'h07,
        OP_XOR  = 8'h08,
        OP_TEST = 8'h09,
        OP_INC  = 8'h0A,
        OP_DEC  = 8'h0B,
        OP_NEG  = 8'h0C,
        OP_NOT  = 8'h0D,
        OP_MOV  = 8'h0E,
        OP_SHL  = 8'h0F,
        OP_SHR  = 8'h10,
        OP_SAR  = 8'h11,
        OP_MUL  = 8'h12,
        OP_IMUL = 8'h13
    } opcode_t;

    localparam int CF_BIT = 0;
    localparam int PF_BIT = 2;
    localparam int AF_BIT = 4;
    localparam int ZF_BIT = 6;
    localparam int SF_BIT = 7;
    localparam int OF_BIT = 11;

    localparam logic [63:0] FLAG_MASK = 64'h0000_0000_0000_08D5;

    typedef struct packed {
        logic [63:0] value;
        logic        cf;
        logic        af;
        logic        of;
    } arith_t;

    typedef enum logic [1:0] {
        FSEL_CALC = 2'd0,  // computed bits merged into oprd3
        FSEL_PASS = 2'd1,  // oprd3 unchanged
        FSEL_ZERO = 2'd2   // no micro-op this cycle
    } flag_sel_t;

endpackage

// File: rtl/alu_if.sv
// alu_if -- Data-Fetch -> EXE -> MEM bundle for the ALU.
//   enable            : valid micro-op presented this cycle
//   opcode            : ALU operation (alu_pkg::opcode_t values)
//   oprd1/oprd2/oprd3 : first source, second source, current RFLAGS
//   result/flags      : combinational 128-bit result and new RFLAGS
//   mem_valid         : registered strobe, high the cycle after an enabled op
// master = pipeline driver side, slave = ALU side.
interface alu_if;
    import alu_pkg::*;

    logic         enable;
    logic [7:0]   opcode;
    logic [63:0]  oprd1;
    logic [63:0]  oprd2;
    logic [63:0]  oprd3;
    logic [127:0] result;
    logic [63:0]  flags;
    logic         mem_valid;

    modport master (
        output enable, opcode, oprd1, oprd2, oprd3,
        input  result, flags, mem_valid
    );

    modport slave (
        input  enable, opcode, oprd1, oprd2, oprd3,
        output result, flags, mem_valid
    );

endinterface

// File: rtl/alu_flags.sv
// alu_flags -- derives PF/ZF/SF from a 64-bit value and merges them, together
// with the supplied CF/AF/OF, into the incoming RFLAGS word. Bits outside
// FLAG_MASK are copied from base untouched.
//   value : 64-bit value the status flags describe
//   base  : incoming RFLAGS (oprd3)
//   cf/af/of : carry, auxiliary carry and overflow computed by the caller
//   flags : merged RFLAGS
module alu_flags
    import alu_pkg::*;
(
    input  logic [63:0] value,
    input  logic [63:0] base,
    input  logic        cf,
    input  logic        af,
    input  logic        of,
    output logic [63:0] flags
);

    // PF reflects even parity of the low byte only.
    function automatic logic even_parity(input logic [7:0] b);
        return ~^b;
    endfunction

    always_comb begin
        flags         = base & ~FLAG_MASK;
        flags[CF_BIT] = cf;
        flags[PF_BIT] = even_parity(value[7:0]);
        flags[AF_BIT] = af;
        flags[ZF_BIT] = (value == 64'd0);
        flags[SF_BIT] = value[63];
        flags[OF_BIT] = of;
    end

endmodule

// File: rtl/alu.sv
// alu -- combinational 64-bit integer execution unit for the EXE stage.
//   clk, reset : pipeline clock, synchronous active-high reset
//   bus        : alu_if.slave (enable, opcode, oprd1..3 in; result, flags,
//                mem_valid out)
// result/flags are zero-latency functions of the inputs; mem_valid is the only
// state and follows enable by one clock.
module alu
    import alu_pkg::*;
(
    input  logic  clk,
    input  logic  reset,
    alu_if.slave  bus
);

    // Shared adder/subtractor. AF is the carry/borrow into bit 4, which is
    // x^y^r at bit 4 for both addition and subtraction.
    function automatic arith_t addsub(input logic [63:0] x, input logic [63:0] y,
                                      input logic cin, input logic sub);
        logic [64:0] wide;
        arith_t      o;
        if (sub)
            wide = {1'b0, x} - {1'b0, y} - {64'd0, cin};
        else
            wide = {1'b0, x} + {1'b0, y} + {64'd0, cin};
        o.value = wide[63:0];
        o.cf    = wide[64];
        o.af    = x[4] ^ y[4] ^ wide[4];
        if (sub)
            o.of = (x[63] != y[63]) && (wide[63] != x[63]);
        else
            o.of = (x[63] == y[63]) && (wide[63] != x[63]);
        return o;
    endfunction

    logic [63:0]         a;
    logic [63:0]         b;
    logic [63:0]         c;
    logic [5:0]          cnt;

    logic [63:0]         ax;
    logic [63:0]         ay;
    logic                acin;
    logic                asub;
    arith_t              ar;

    logic [64:0]         shl_ext;
    logic [64:0]         shr_ext;
    logic signed [64:0]  sar_ext;

    logic [127:0]        uprod;
    logic signed [63:0]  s1;
    logic signed [63:0]  s2;
    logic signed [127:0] s1x;
    logic signed [127:0] s2x;
    logic signed [127:0] sprod;

    logic [127:0]        res;
    logic [63:0]         fval;
    logic                cf;
    logic                af;
    logic                of;
    flag_sel_t           fsel;
    logic [63:0]         merged;

    logic                vld_p1;

    assign a   = bus.oprd1;
    assign b   = bus.oprd2;
    assign c   = bus.oprd3;
    assign cnt = b[5:0];

    // Operand steering so all add/sub-style opcodes share one adder.
    always_comb begin
        ax   = a;
        ay   = b;
        acin = 1'b0;
        asub = 1'b0;
        case (bus.opcode)
            OP_ADC:         acin = c[CF_BIT];
            OP_SUB, OP_CMP: asub = 1'b1;
            OP_SBB: begin
                asub = 1'b1;
                acin = c[CF_BIT];
            end
            OP_INC:         ay = 64'd1;
            OP_DEC: begin
                ay   = 64'd1;
                asub = 1'b1;
            end
            OP_NEG: begin
                ax   = 64'd0;
                ay   = a;
                asub = 1'b1;
            end
            default: ;
        endcase
    end

    assign ar = addsub(ax, ay, acin, asub);

    // One guard bit beside the operand catches the last bit shifted out.
    assign shl_ext = {1'b0, a} << cnt;
    assign shr_ext = {a, 1'b0} >> cnt;
    assign sar_ext = $signed({a, 1'b0}) >>> cnt;

    assign uprod = {64'd0, a} * {64'd0, b};
    assign s1    = a;
    assign s2    = b;
    assign s1x   = s1;
    assign s2x   = s2;
    assign sprod = s1x * s2x;

    always_comb begin
        res  = '0;
        fval = '0;
        cf   = 1'b0;
        af   = 1'b0;
        of   = 1'b0;
        fsel = FSEL_PASS;
        if (!bus.enable) begin
            fsel = FSEL_ZERO;
        end else begin
            case (bus.opcode)
                OP_ADD, OP_ADC, OP_SUB, OP_SBB: begin
                    res  = {64'd0, ar.value};
                    fval = ar.value;
                    cf   = ar.cf;
                    af   = ar.af;
                    of   = ar.of;
                    fsel = FSEL_CALC;
                end
                OP_CMP: begin
                    res  = {64'd0, a};
                    fval = ar.value;
                    cf   = ar.cf;
                    af   = ar.af;
                    of   = ar.of;
                    fsel = FSEL_CALC;
                end
                OP_AND, OP_OR, OP_XOR: begin
                    if (bus.opcode == OP_AND)     fval = a & b;
                    else if (bus.opcode == OP_OR) fval = a | b;
                    else                          fval = a ^ b;
                    res  = {64'd0, fval};
                    fsel = FSEL_CALC;
                end
                OP_TEST: begin
                    res  = {64'd0, a};
                    fval = a & b;
                    fsel = FSEL_CALC;
                end
                OP_INC, OP_DEC: begin
                    res  = {64'd0, ar.value};
                    fval = ar.value;
                    cf   = c[CF_BIT];
                    af   = ar.af;
                    of   = ar.of;
                    fsel = FSEL_CALC;
                end
                OP_NEG: begin
                    res  = {64'd0, ar.value};
                    fval = ar.value;
                    cf   = (a != 64'd0);
                    af   = ar.af;
                    of   = ar.of;
                    fsel = FSEL_CALC;
                end
                OP_NOT: res = {64'd0, ~a};
                OP_MOV: res = {64'd0, b};
                OP_SHL: begin
                    if (cnt == 6'd0) begin
                        res = {64'd0, a};
                    end else begin
                        res  = {64'd0, shl_ext[63:0]};
                        fval = shl_ext[63:0];
                        cf   = shl_ext[64];
                        of   = (cnt == 6'd1) ? (shl_ext[63] ^ shl_ext[64]) : 1'b0;
                        fsel = FSEL_CALC;
                    end
                end
                OP_SHR: begin
                    if (cnt == 6'd0) begin
                        res = {64'd0, a};
                    end else begin
                        res  = {64'd0, shr_ext[64:1]};
                        fval = shr_ext[64:1];
                        cf   = shr_ext[0];
                        of   = (cnt == 6'd1) ? a[63] : 1'b0;
                        fsel = FSEL_CALC;
                    end
                end
                OP_SAR: begin
                    if (cnt == 6'd0) begin
                        res = {64'd0, a};
                    end else begin
                        res  = {64'd0, sar_ext[64:1]};
                        fval = sar_ext[64:1];
                        cf   = sar_ext[0];
                        fsel = FSEL_CALC;
                    end
                end
                OP_MUL: begin
                    res  = uprod;
                    fval = uprod[63:0];
                    cf   = (uprod[127:64] != 64'd0);
                    of   = cf;
                    fsel = FSEL_CALC;
                end
                OP_IMUL: begin
                    res  = sprod;
                    fval = sprod[63:0];
                    // Overflow when the high half is not just the sign of the low half.
                    cf   = (sprod[127:64] != {64{sprod[63]}});
                    of   = cf;
                    fsel = FSEL_CALC;
                end
                default: ;
            endcase
        end
    end

    alu_flags u_flags (
        .value (fval),
        .base  (c),
        .cf    (cf),
        .af    (af),
        .of    (of),
        .flags (merged)
    );

    assign bus.result = res;

    always_comb begin
        case (fsel)
            FSEL_CALC: bus.flags = merged;
            FSEL_PASS: bus.flags = c;
            default:   bus.flags = '0;
        endcase
    end

    // EXE -> MEM boundary: completion strobe for the micro-op registered downstream.
    always_ff @(posedge clk) begin
        if (reset)
            vld_p1 <= 1'b0;
        else
            vld_p1 <= bus.enable;
    end

    assign bus.mem_valid = vld_p1;

endmodule

// File: tb/tb_alu.sv
module tb_alu;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    alu_if bus();

    alu dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    localparam logic signed [65:0]  S64_MAX  = 66'sh0_7FFF_FFFF_FFFF_FFFF;
    localparam logic signed [65:0]  S64_MIN  = -66'sh0_8000_0000_0000_0000;
    localparam logic signed [127:0] P64_MAX  = 128'sh7FFF_FFFF_FFFF_FFFF;
    localparam logic signed [127:0] P64_MIN  = -128'sh8000_0000_0000_0000;

    // Reference model: exact-width arithmetic, overflow by range test.
    function automatic void model(input logic en, input logic [7:0] op,
                                  input logic [63:0] a, input logic [63:0] b,
                                  input logic [63:0] c,
                                  output logic [127:0] r, output logic [63:0] f);
        logic [63:0]         v;
        logic [63:0]         x;
        logic [63:0]         y;
        bit                  calc, cf, af, of, ci, sub, arith;
        int                  n;
        logic signed [65:0]  ss;
        logic [127:0]        up;
        logic signed [127:0] sp;
        r = '0; f = c; v = '0; calc = 0; cf = 0; af = 0; of = 0;
        n = int'(b[5:0]);
        x = a; y = b; ci = 0; sub = 0; arith = 0;
        if (!en) begin
            f = '0;
            return;
        end
        case (op)
            OP_ADD:         arith = 1;
            OP_ADC:  begin arith = 1; ci = c[0]; end
            OP_SUB, OP_CMP: begin arith = 1; sub = 1; end
            OP_SBB:  begin arith = 1; sub = 1; ci = c[0]; end
            OP_INC:  begin arith = 1; y = 64'd1; end
            OP_DEC:  begin arith = 1; y = 64'd1; sub = 1; end
            OP_NEG:  begin arith = 1; x = 64'd0; y = a; sub = 1; end
            default: ;
        endcase
        if (arith) begin
            if (!sub) begin
                ss = $signed({{2{x[63]}}, x}) + $signed({{2{y[63]}}, y}) + $signed({65'd0, ci});
                cf = (({1'b0, x} + {1'b0, y} + 65'(ci)) > 65'h0_FFFF_FFFF_FFFF_FFFF);
                af = (int'(x[3:0]) + int'(y[3:0]) + int'(ci)) > 15;
            end else begin
                ss = $signed({{2{x[63]}}, x}) - $signed({{2{y[63]}}, y}) - $signed({65'd0, ci});
                cf = ({1'b0, x} < ({1'b0, y} + 65'(ci)));
                af = int'(x[3:0]) < (int'(y[3:0]) + int'(ci));
            end
            v    = ss[63:0];
            of   = (ss > S64_MAX) || (ss < S64_MIN);
            calc = 1;
            r    = (op == OP_CMP) ? {64'd0, a} : {64'd0, v};
            if (op == OP_INC || op == OP_DEC) cf = c[0];
            if (op == OP_NEG) cf = (a != 0);
        end else begin
            case (op)
                OP_AND:  begin v = a & b; r = {64'd0, v}; calc = 1; end
                OP_OR:   begin v = a | b; r = {64'd0, v}; calc = 1; end
                OP_XOR:  begin v = a ^ b; r = {64'd0, v}; calc = 1; end
                OP_TEST: begin v = a & b; r = {64'd0, a}; calc = 1; end
                OP_NOT:  r = {64'd0, ~a};
                OP_MOV:  r = {64'd0, b};
                OP_SHL, OP_SHR, OP_SAR: begin
                    if (n == 0) begin
                        r = {64'd0, a};
                    end else begin
                        calc = 1;
                        if (op == OP_SHL) begin
                            v  = a << n;
                            cf = a[64 - n];
                            of = (n == 1) ? (v[63] ^ cf) : 0;
                        end else if (op == OP_SHR) begin
                            v  = a >> n;
                            cf = a[n - 1];
                            of = (n == 1) ? a[63] : 0;
                        end else begin
                            v  = $signed(a) >>> n;
                            cf = a[n - 1];
                        end
                        r = {64'd0, v};
                    end
                end
                OP_MUL: begin
                    up = {64'd0, a} * {64'd0, b};
                    r = up; v = up[63:0]; calc = 1;
                    cf = (up > 128'h0000_0000_0000_0000_FFFF_FFFF_FFFF_FFFF);
                    of = cf;
                end
                OP_IMUL: begin
                    sp = $signed({{64{a[63]}}, a}) * $signed({{64{b[63]}}, b});
                    r = sp; v = sp[63:0]; calc = 1;
                    cf = (sp > P64_MAX) || (sp < P64_MIN);
                    of = cf;
                end
                default: r = '0;
            endcase
        end
        if (calc) begin
            f[0]  = cf;
            f[2]  = ($countones(v[7:0]) % 2) == 0;
            f[4]  = af;
            f[6]  = (v == 64'd0);
            f[7]  = v[63];
            f[11] = of;
        end
    endfunction

    function automatic logic [63:0] pick();
        case ($urandom_range(0, 7))
            0:       return 64'd0;
            1:       return '1;
            2:       return 64'h8000_0000_0000_0000;
            3:       return 64'h7FFF_FFFF_FFFF_FFFF;
            4:       return 64'($urandom_range(0, 3));
            default: return {$urandom, $urandom};
        endcase
    endfunction

    task automatic drive(input logic en, input logic [7:0] op, input logic [63:0] a,
                         input logic [63:0] b, input logic [63:0] c);
        @(negedge clk);
        bus.enable = en;
        bus.opcode = op;
        bus.oprd1  = a;
        bus.oprd2  = b;
        bus.oprd3  = c;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.enable = 1'b1; bus.opcode = OP_ADD;
        bus.oprd1 = 64'd5; bus.oprd2 = 64'd7; bus.oprd3 = 64'h202;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (bus.mem_valid !== 1'b0) begin
                failures++;
                $display("FAIL reset_mem_valid got=%b exp=0", bus.mem_valid);
            end
        end
        drive(1'b0, OP_ADD, 64'd5, 64'd7, 64'h202);
        reset = 1'b0;
        checks++;
        if (bus.result !== 128'd0) begin
            failures++;
            $display("FAIL disabled_result got=%h exp=0", bus.result);
        end
        checks++;
        if (bus.flags !== 64'd0) begin
            failures++;
            $display("FAIL disabled_flags got=%h exp=0", bus.flags);
        end
    endtask

    task automatic test_vectors();
        drive(1'b1, OP_ADD, '1, 64'd1, 64'd0);
        checks++;
        if (bus.result !== 128'd0 || bus.flags !== 64'h55) begin
            failures++;
            $display("FAIL vec_add got=%h/%h exp=0/55", bus.result, bus.flags);
        end
        drive(1'b1, OP_SUB, 64'h8000_0000_0000_0000, 64'd1, 64'd0);
        checks++;
        if (bus.result !== 128'h7FFF_FFFF_FFFF_FFFF || bus.flags !== 64'h814) begin
            failures++;
            $display("FAIL vec_sub got=%h/%h exp=7fffffffffffffff/814", bus.result, bus.flags);
        end
        drive(1'b1, OP_MUL, '1, 64'd2, 64'd0);
        checks++;
        if (bus.result !== 128'h1_FFFF_FFFF_FFFF_FFFE || bus.flags !== 64'h881) begin
            failures++;
            $display("FAIL vec_mul got=%h/%h exp=1fffffffffffffffe/881", bus.result, bus.flags);
        end
        drive(1'b1, OP_IMUL, 64'hFFFF_FFFF_FFFF_FFFE, 64'd3, 64'd0);
        checks++;
        if (bus.result !== 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFA || bus.flags !== 64'h84) begin
            failures++;
            $display("FAIL vec_imul got=%h/%h exp=-6/84", bus.result, bus.flags);
        end
        drive(1'b1, OP_SHL, 64'd1, 64'd64, 64'h202);
        checks++;
        if (bus.result !== 128'd1 || bus.flags !== 64'h202) begin
            failures++;
            $display("FAIL vec_shl64 got=%h/%h exp=1/202", bus.result, bus.flags);
        end
        drive(1'b1, 8'h7F, 64'd9, 64'd9, 64'hABC);
        checks++;
        if (bus.result !== 128'd0 || bus.flags !== 64'hABC) begin
            failures++;
            $display("FAIL vec_undef got=%h/%h exp=0/abc", bus.result, bus.flags);
        end
    endtask

    task automatic test_shift_counts();
        logic [127:0] er;
        logic [63:0]  ef;
        logic [7:0]   ops [3];
        int           cnts [7];
        ops  = '{OP_SHL, OP_SHR, OP_SAR};
        cnts = '{0, 1, 2, 31, 63, 64, 65};
        foreach (ops[i]) begin
            foreach (cnts[j]) begin
                logic [63:0] a, b, c;
                a = {$urandom, $urandom} | 64'h8000_0000_0000_0001;
                b = {$urandom, $urandom};
                b[6:0] = 7'(cnts[j]);
                c = {$urandom, $urandom};
                drive(1'b1, ops[i], a, b, c);
                model(1'b1, ops[i], a, b, c, er, ef);
                checks++;
                if (bus.result !== er || bus.flags !== ef) begin
                    failures++;
                    $display("FAIL shift op=%h cnt=%0d a=%h got=%h/%h exp=%h/%h",
                             ops[i], cnts[j], a, bus.result, bus.flags, er, ef);
                end
            end
        end
    endtask

    task automatic test_random();
        logic [127:0] er;
        logic [63:0]  ef;
        for (int i = 0; i < 1500; i++) begin
            logic [7:0]  op;
            logic [63:0] a, b, c;
            logic        en;
            op = ($urandom_range(0, 30) == 0) ? 8'($urandom) : 8'($urandom_range(0, 21));
            a  = pick();
            b  = pick();
            c  = {$urandom, $urandom};
            en = ($urandom_range(0, 9) != 0);
            drive(en, op, a, b, c);
            model(en, op, a, b, c, er, ef);
            checks++;
            if (bus.result !== er) begin
                failures++;
                $display("FAIL rand_result en=%b op=%h a=%h b=%h c=%h got=%h exp=%h",
                         en, op, a, b, c, bus.result, er);
            end
            checks++;
            if (bus.flags !== ef) begin
                failures++;
                $display("FAIL rand_flags en=%b op=%h a=%h b=%h c=%h got=%h exp=%h",
                         en, op, a, b, c, bus.flags, ef);
            end
        end
    endtask

    task automatic test_back_to_back();
        // single pulse
        @(negedge clk); bus.enable = 1'b0;
        @(negedge clk); bus.enable = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.mem_valid !== 1'b1) begin
            failures++;
            $display("FAIL pulse_hi got=%b exp=1", bus.mem_valid);
        end
        bus.enable = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.mem_valid !== 1'b0) begin
            failures++;
            $display("FAIL pulse_lo got=%b exp=0", bus.mem_valid);
        end
        // three consecutive enables
        bus.enable = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (bus.mem_valid !== 1'b1) begin
                failures++;
                $display("FAIL b2b_hi%0d got=%b exp=1", k, bus.mem_valid);
            end
        end
        // reset mid-stream with enable still high
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.mem_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_kill got=%b exp=0", bus.mem_valid);
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.mem_valid !== 1'b1) begin
            failures++;
            $display("FAIL after_reset got=%b exp=1", bus.mem_valid);
        end
        bus.enable = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.mem_valid !== 1'b0) begin
            failures++;
            $display("FAIL final_lo got=%b exp=0", bus.mem_valid);
        end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_shift_counts();
        test_random();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
